dadd_seq: RTL and testbench

- Per-phrase sequencer for the blitter adder A-operand multiplexer.
- Holds the 3-bit daddasel select stable across a programmed sequence of adder passes for every phrase of a blit:
  - data pass: dstd / srcd / patd
  - Z-low pass: srcz1
  - Z-high pass: srcz2
- Handshakes each pass with the downstream adder/writeback stage.
- Emits the load strobes for the data and Z result registers.
- Sits between the blitter inner-loop control and the data-path adder-operand mux.

---
 rtl/dadd_seq_if.sv | 36 +++
 rtl/dadd_seq.sv | 137 +++++++++++++
 tb/tb_dadd_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dadd_seq_if.sv
// Handshake/bus bundle between blitter inner-loop control and the adder-operand sequencer.
//   master : inner-loop control side (drives start/abort/config/step_ack, observes status)
//   slave  : dadd_seq (observes commands, drives operand select, strobes and status)
// Signals:
//   start, abort, phrase_cnt[CNT_W], gourd, srcadd, gourz, step_ack   (master -> slave)
//   daddasel[3], dadd_en, dst_ld, zlo_ld, zhi_ld, busy, done,
//   remaining[CNT_W]                                                  (slave -> master)
interface dadd_seq_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] phrase_cnt;
  logic             gourd;
  logic             srcadd;
  logic             gourz;
  logic             step_ack;
  logic [2:0]       daddasel;
  logic             dadd_en;
  logic             dst_ld;
  logic             zlo_ld;
  logic             zhi_ld;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;

  modport master (
    output start, abort, phrase_cnt, gourd, srcadd, gourz, step_ack,
    input  daddasel, dadd_en, dst_ld, zlo_ld, zhi_ld, busy, done, remaining
  );

  modport slave (
    input  start, abort, phrase_cnt, gourd, srcadd, gourz, step_ack,
    output daddasel, dadd_en, dst_ld, zlo_ld, zhi_ld, busy, done, remaining
  );
endinterface

// File: rtl/dadd_seq.sv
// Per-phrase sequencer for the blitter adder A-operand mux. For each phrase it presents a data
// pass (dstd/srcd/patd) and, when Z interpolation is on, a Z-low and a Z-high pass, holding
// daddasel stable until the downstream stage acks, and emits the matching result-load strobe.
// Ports:
//   sys_clk   : clock, all state changes on rising edge
//   reset     : synchronous active-high reset
//   bus       : dadd_seq_if.slave handshake/config/status bundle
//   stall_cnt : [15:0] cycles with dadd_en=1 and step_ack=0, saturating
//               (present only when DADD_SEQ_STATS_EN is defined)
// Optional feature macro: DADD_SEQ_STATS_EN
module dadd_seq #(
  parameter int unsigned CNT_W = 16
) (
  input  logic         sys_clk,
  input  logic         reset,
  dadd_seq_if.slave    bus
`ifdef DADD_SEQ_STATS_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StData = 3'd1;
  localparam logic [2:0] StZlo  = 3'd2;
  localparam logic [2:0] StZhi  = 3'd3;
  localparam logic [2:0] StFin  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             gourd_q, gourd_d;
  logic             srcadd_q, srcadd_d;
  logic             gourz_q, gourz_d;
  logic             phrase_end;
  logic             start_acc;
  logic             kill;

  // Start is accepted only from idle, and abort beats it.
  assign start_acc = (state_q == StIdle) && bus.start && !bus.abort;
  // Suppresses same-cycle strobes/done when the current pass is being cancelled.
  assign kill      = bus.abort || reset;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    gourd_d    = gourd_q;
    srcadd_d   = srcadd_q;
    gourz_d    = gourz_q;
    phrase_end = 1'b0;
    if (bus.abort) begin
      state_d = StIdle;
      rem_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            gourd_d  = bus.gourd;
            srcadd_d = bus.srcadd;
            gourz_d  = bus.gourz;
            rem_d    = bus.phrase_cnt;
            state_d  = (bus.phrase_cnt != '0) ? StData : StFin;
          end
        end
        StData: begin
          if (bus.step_ack) begin
            if (gourz_q) state_d = StZlo;
            else         phrase_end = 1'b1;
          end
        end
        StZlo:   if (bus.step_ack) state_d = StZhi;
        StZhi:   if (bus.step_ack) phrase_end = 1'b1;
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
      if (phrase_end) begin
        if (rem_q != '0) rem_d = rem_q - 1'b1;
        // Last phrase when the pre-decrement count is 1 (or already 0).
        state_d = (rem_q == CNT_W'(1) || rem_q == '0) ? StFin : StData;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      gourd_q  <= 1'b0;
      srcadd_q <= 1'b0;
      gourz_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      gourd_q  <= gourd_d;
      srcadd_q <= srcadd_d;
      gourz_q  <= gourz_d;
    end
  end

  // Outputs decode from registered state and latched config, so they are glitch-free
  // and stable for the whole pass; only the strobes follow step_ack combinationally.
  always_comb begin
    bus.daddasel = 3'b000;
    bus.dadd_en  = 1'b0;
    case (state_q)
      StData: begin
        bus.daddasel = gourd_q ? 3'b101 : (srcadd_q ? 3'b100 : 3'b000);
        bus.dadd_en  = 1'b1;
      end
      StZlo: begin
        bus.daddasel = 3'b110;
        bus.dadd_en  = 1'b1;
      end
      StZhi: begin
        bus.daddasel = 3'b111;
        bus.dadd_en  = 1'b1;
      end
      default: ;
    endcase
    bus.dst_ld    = (state_q == StData) && bus.step_ack && !kill;
    bus.zlo_ld    = (state_q == StZlo)  && bus.step_ack && !kill;
    bus.zhi_ld    = (state_q == StZhi)  && bus.step_ack && !kill;
    bus.done      = (state_q == StFin)  && !kill;
    bus.busy      = (state_q != StIdle);
    bus.remaining = rem_q;
  end

`ifdef DADD_SEQ_STATS_EN
  always_ff @(posedge sys_clk) begin
    if (reset || start_acc) begin
      stall_cnt <= '0;
    end else if (bus.dadd_en && !bus.step_ack && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dadd_seq.sv
module tb_dadd_seq;
  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  int   n_vec   = 0;
  int   n_err   = 0;
  logic [2:0] exp_sel [3];

  dadd_seq_if #(.CNT_W(16)) bus ();

`ifdef DADD_SEQ_STATS_EN
  logic [15:0] stall_cnt;
`endif

  dadd_seq #(.CNT_W(16)) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .bus       (bus)
`ifdef DADD_SEQ_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    exp_sel[0] = 3'b101;
    exp_sel[1] = 3'b110;
    exp_sel[2] = 3'b111;
    bus.start = 0; bus.abort = 0; bus.phrase_cnt = 0;
    bus.gourd = 0; bus.srcadd = 0; bus.gourz = 0; bus.step_ack = 1;
    tick(); tick();
    reset = 0;
    #1;
    // Reset state, step_ack high in IDLE must produce nothing
    check("rst_sel",   32'(bus.daddasel), 0);
    check("rst_en",    32'(bus.dadd_en), 0);
    check("rst_dst",   32'(bus.dst_ld), 0);
    check("rst_busy",  32'(bus.busy), 0);
    check("rst_done",  32'(bus.done), 0);
    check("rst_rem",   32'(bus.remaining), 0);

    // Basic path: 3 phrases, source add, no Z, ack tied high
    bus.phrase_cnt = 3; bus.srcadd = 1; bus.start = 1;
    tick();
    bus.start = 0; bus.phrase_cnt = 0; bus.gourd = 1; // config change must not matter
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bas_sel",  32'(bus.daddasel), 4);
      check("bas_dst",  32'(bus.dst_ld), 1);
      check("bas_rem",  32'(bus.remaining), 32'(3 - i));
      check("bas_busy", 32'(bus.busy), 1);
      tick();
    end
    check("bas_done", 32'(bus.done), 1);
    check("bas_fbsy", 32'(bus.busy), 1);
    check("bas_fen",  32'(bus.dadd_en), 0);
    check("bas_frem", 32'(bus.remaining), 0);
    tick();
    check("bas_idle", 32'(bus.busy), 0);
    check("bas_dn0",  32'(bus.done), 0);

    // Z passes with ack every second cycle
    bus.gourd = 1; bus.gourz = 1; bus.srcadd = 0; bus.phrase_cnt = 2;
    bus.step_ack = 0; bus.start = 1;
    tick();
    bus.start = 0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 3; k++) begin
        bus.step_ack = 0;
        #1;
        check("z_sel_w", 32'(bus.daddasel), 32'(exp_sel[k]));
        check("z_ld_w",  32'({bus.dst_ld, bus.zlo_ld, bus.zhi_ld}), 0);
        check("z_rem",   32'(bus.remaining), 32'(2 - p));
        tick();
        bus.step_ack = 1;
        #1;
        check("z_sel_a", 32'(bus.daddasel), 32'(exp_sel[k]));
        check("z_ld_a",  32'({bus.dst_ld, bus.zlo_ld, bus.zhi_ld}), 32'(3'b100 >> k));
        tick();
      end
    end
    bus.step_ack = 0;
    #1;
    check("z_done", 32'(bus.done), 1);
    check("z_rem0", 32'(bus.remaining), 0);
`ifdef DADD_SEQ_STATS_EN
    check("z_stall", 32'(stall_cnt), 6);
`endif
    tick();

    // Zero count
    bus.phrase_cnt = 0; bus.start = 1;
    tick();
    bus.start = 0;
    check("zc_done", 32'(bus.done), 1);
    check("zc_en",   32'(bus.dadd_en), 0);
    check("zc_rem",  32'(bus.remaining), 0);
    tick();
    check("zc_idle", 32'(bus.busy), 0);

    // Abort and start together in IDLE: abort wins
    bus.phrase_cnt = 5; bus.start = 1; bus.abort = 1;
    tick();
    bus.start = 0; bus.abort = 0;
    check("as_busy", 32'(bus.busy), 0);
    check("as_rem",  32'(bus.remaining), 0);

    // Abort in ZLO of first phrase of 4, with ack high
    bus.gourd = 0; bus.srcadd = 0; bus.gourz = 1; bus.phrase_cnt = 4;
    bus.step_ack = 1; bus.start = 1;
    tick();
    bus.start = 0;
    check("ab_dsel", 32'(bus.daddasel), 0);
    tick();
    check("ab_zsel", 32'(bus.daddasel), 6);
    bus.abort = 1;
    #1;
    check("ab_zlo",  32'(bus.zlo_ld), 0);
    check("ab_done", 32'(bus.done), 0);
    tick();
    bus.abort = 0;
    #1;
    check("ab_busy", 32'(bus.busy), 0);
    check("ab_rem",  32'(bus.remaining), 0);
    check("ab_en",   32'(bus.dadd_en), 0);
    tick();
    check("ab_nodn", 32'(bus.done), 0);

    // Ignored start while busy, then reset mid-ZHI
    bus.gourd = 0; bus.srcadd = 1; bus.gourz = 1; bus.phrase_cnt = 2; bus.start = 1;
    tick();
    check("is_sel",  32'(bus.daddasel), 4);
    bus.phrase_cnt = 9;  // start still high while busy
    tick();
    bus.start = 0;
    check("is_rem",  32'(bus.remaining), 2);
    check("is_zlo",  32'(bus.daddasel), 6);
    tick();
    check("is_zhi",  32'(bus.daddasel), 7);
    reset = 1;
    tick();
    reset = 0;
    #1;
    check("mr_busy", 32'(bus.busy), 0);
    check("mr_sel",  32'(bus.daddasel), 0);
    check("mr_en",   32'(bus.dadd_en), 0);
    check("mr_rem",  32'(bus.remaining), 0);
    check("mr_done", 32'(bus.done), 0);
    check("mr_ld",   32'({bus.dst_ld, bus.zlo_ld, bus.zhi_ld}), 0);
    tick();
    check("mr_nodn", 32'(bus.done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
